sr_lsu: RTL and testbench

- Parametrised load/store unit for the sr_cpu core. Replaces the combinational address-generation/pause logic with a registered request/response engine.
- Supports byte, half and word accesses with sign/zero extension and per-byte lane enables.
- Sits between the CPU datapath (rs1, immediate, rs2, funct3) and the node RAM controller.
- Stalls the single-cycle core until the access completes, or until a response timeout expires.

---
 rtl/sr_lsu_pkg.sv | 42 ++++
 rtl/sr_lsu_if.sv | 45 ++++
 rtl/sr_lsu_align.sv | 44 ++++
 rtl/sr_lsu.sv | 166 ++++++++++++++++
 tb/tb_sr_lsu.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sr_lsu_pkg.sv
// ============================================================================
// Module   : sr_lsu_pkg
// Brief    : Shared encodings and lane helpers for the sr_lsu load/store unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sr_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Encoding 11 behaves as a word access.
    function automatic size_t norm_size(input logic [1:0] i_s);
        case (i_s)
            2'b00:   return SIZE_B;
            2'b01:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

    function automatic logic [1:0] lane_of(input size_t i_size, input logic [1:0] i_ea_lo);
        case (i_size)
            SIZE_B:  return i_ea_lo;
            SIZE_H:  return {i_ea_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sr_lsu_if.sv
// ============================================================================
// Module   : sr_lsu_if
// Brief    : CPU-request and node-RAM bus bundle for sr_lsu (slave = LSU view).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sr_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_base;
    logic [31:0]       req_offset;
    logic [31:0]       req_wdata;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              cpu_err;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_base, req_offset, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output cpu_stall, cpu_rdata, cpu_err,
        output mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_base, req_offset, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  cpu_stall, cpu_rdata, cpu_err,
        input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/sr_lsu_align.sv
// ============================================================================
// Module   : sr_lsu_align
// Brief    : Byte-lane steering: store enables/data and load extraction+extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sr_lsu_align
    import sr_lsu_pkg::*;
(
    input  size_t       i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shr;
    logic        w_sext;

    assign o_wdata = i_wdata << {i_lane, 3'b000};
    assign w_shr   = i_rdata >> {i_lane, 3'b000};
    assign w_sext  = ~i_unsigned;

    always_comb begin
        o_be    = 4'b1111;
        o_rdata = w_shr;
        case (i_size)
            SIZE_B: begin
                o_be    = 4'b0001 << i_lane;
                o_rdata = {{24{w_sext & w_shr[7]}}, w_shr[7:0]};
            end
            SIZE_H: begin
                o_be    = 4'b0011 << i_lane;
                o_rdata = {{16{w_sext & w_shr[15]}}, w_shr[15:0]};
            end
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/sr_lsu.sv
// ============================================================================
// Module   : sr_lsu
// Brief    : Registered load/store engine stalling sr_cpu until the access
//            completes or times out. Option: SR_LSU_MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sr_lsu
    import sr_lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  wire logic clk,
    input  wire logic rst,
    sr_lsu_if.slave   bus
);
    localparam bit                 C_TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] C_TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   w_ea;
    size_t               w_size_n, w_al_size, r_size;
    logic [1:0]          w_lane_ea, w_al_lane, r_lane;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata, w_rdata;
    logic                w_issue, w_abort, w_stall, w_tmo;
    logic                r_unsigned;
    logic [TIMEOUT_W-1:0] r_tcnt;
    logic                r_mem_valid, r_mem_we, r_cpu_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [3:0]          r_mem_be;
    logic [31:0]         r_mem_wdata, r_cpu_rdata;

    assign w_ea      = bus.req_base[ADDR_W-1:0] + bus.req_offset[ADDR_W-1:0];
    assign w_size_n  = norm_size(bus.req_size);
    assign w_lane_ea = lane_of(w_size_n, w_ea[1:0]);
    assign w_tmo     = C_TMO_EN && (r_tcnt == C_TMO_LAST);

    // One aligner serves both sides: request fields in IDLE, latched ones after.
    assign w_al_size = (r_state == ST_IDLE) ? w_size_n  : r_size;
    assign w_al_lane = (r_state == ST_IDLE) ? w_lane_ea : r_lane;

    sr_lsu_align u_align (
        .i_size     (w_al_size),
        .i_lane     (w_al_lane),
        .i_unsigned (r_unsigned),
        .i_wdata    (bus.req_wdata),
        .i_rdata    (bus.mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

`ifdef SR_LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_size_n == SIZE_H) && w_ea[0]) ||
                        ((w_size_n == SIZE_W) && (w_ea[1:0] != 2'b00));
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_abort = 1'b0;
        w_stall = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_stall = bus.req_valid;
                if (bus.req_valid) begin
`ifdef SR_LSU_MISALIGN_TRAP_EN
                    if (w_misalign) begin
                        w_next  = ST_DONE;
                        w_abort = 1'b1;
                    end else begin
                        w_next  = ST_REQ;
                        w_issue = 1'b1;
                    end
`else
                    w_next  = ST_REQ;
                    w_issue = 1'b1;
`endif
                end
            end
            ST_REQ: begin
                if (bus.mem_ready) begin
                    w_next = r_mem_we ? ST_DONE : ST_WAIT;
                end else if (w_tmo) begin
                    w_next  = ST_DONE;
                    w_abort = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_next = ST_DONE;
                end else if (w_tmo) begin
                    w_next  = ST_DONE;
                    w_abort = 1'b1;
                end
            end
            default: begin
                w_stall = 1'b0;
                w_next  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_cpu_rdata <= 32'h0;
            r_cpu_err   <= 1'b0;
            r_tcnt      <= '0;
            r_size      <= SIZE_B;
            r_lane      <= 2'b00;
            r_unsigned  <= 1'b0;
        end else begin
            // Error is only ever raised on the transition into DONE, so it lasts one cycle.
            r_cpu_err <= w_abort;
            if (w_issue) begin
                r_mem_valid <= 1'b1;
                r_mem_we    <= bus.req_we;
                r_mem_addr  <= {w_ea[ADDR_W-1:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
                r_size      <= w_size_n;
                r_lane      <= w_lane_ea;
                r_unsigned  <= bus.req_unsigned;
                r_tcnt      <= '0;
            end
            if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if ((r_state == ST_REQ) && (bus.mem_ready || w_abort)) begin
                r_mem_valid <= 1'b0;
            end
            if ((r_state == ST_WAIT) && bus.mem_rvalid) begin
                r_cpu_rdata <= w_rdata;
            end
            if (w_abort) begin
                r_cpu_rdata <= 32'h0;
            end
        end
    end

    assign bus.cpu_stall = w_stall;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_err   = r_cpu_err;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

`default_nettype wire

// File: tb/tb_sr_lsu.sv
// ============================================================================
// Module   : tb_sr_lsu
// Brief    : Randomized self-checking bench for sr_lsu with a transaction model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sr_lsu;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sr_lsu_if #(.ADDR_W(32)) bus ();

    sr_lsu #(
        .ADDR_W         (32),
        .TIMEOUT_W      (8),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One complete access; expectations come from address arithmetic on ea.
    task automatic access(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int rdly, input int vdly);
        logic [31:0] ea, er, byt, ew;
        logic [3:0]  be;
        int          lane, v, nstall;
        bit          mis, trap;
        ea   = base + off;
        mis  = (size == 2'd1 && ea[0]) || (size[1] && ea[1:0] != 2'b00);
        trap = 1'b0;
`ifdef SR_LSU_MISALIGN_TRAP_EN
        trap = mis;
`endif
        if (size == 2'd0)      lane = int'(ea[1:0]);
        else if (size == 2'd1) lane = ea[1] ? 2 : 0;
        else                   lane = 0;
        be  = (size == 2'd0) ? 4'(1 << lane) : (size == 2'd1) ? 4'(3 << lane) : 4'hF;
        ew  = wdata << (8 * lane);
        byt = rdata >> (8 * lane);
        if (size == 2'd0) begin
            v = int'(byt & 32'hFF);
            if (!uns && v >= 128) v -= 256;
            er = 32'(v);
        end else if (size == 2'd1) begin
            v = int'(byt & 32'hFFFF);
            if (!uns && v >= 32768) v -= 65536;
            er = 32'(v);
        end else begin
            er = rdata;
        end

        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_base = base; bus.req_offset = off; bus.req_wdata = wdata;
        #1;
        chk("idle_stall", 32'(bus.cpu_stall), 1);
        nstall = 1;
        step;
        if (trap) begin
            chk("trap_valid", 32'(bus.mem_valid), 0);
            chk("trap_err", 32'(bus.cpu_err), 1);
            chk("trap_rdata", bus.cpu_rdata, 0);
            chk("trap_stall", 32'(bus.cpu_stall), 0);
            bus.req_valid = 1'b0;
            step;
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            chk("req_valid", 32'(bus.mem_valid), 1);
            chk("req_addr", bus.mem_addr, {ea[31:2], 2'b00});
            chk("req_be", 32'(bus.mem_be), 32'(be));
            chk("req_we", 32'(bus.mem_we), 32'(we));
            if (we) chk("req_wdata", bus.mem_wdata, ew);
            nstall += int'(bus.cpu_stall);
            bus.mem_ready = (i == rdly);
            step;
        end
        bus.mem_ready = 1'b0;
        chk("post_acc_valid", 32'(bus.mem_valid), 0);
        if (!we) begin
            for (int j = 0; j <= vdly; j++) begin
                nstall += int'(bus.cpu_stall);
                bus.mem_rvalid = (j == vdly);
                bus.mem_rdata  = (j == vdly) ? rdata : $urandom;
                step;
            end
            bus.mem_rvalid = 1'b0;
        end
        chk("done_stall", 32'(bus.cpu_stall), 0);
        chk("done_err", 32'(bus.cpu_err), 0);
        if (!we) chk("load_data", bus.cpu_rdata, er);
        chk("stall_cycles", 32'(nstall), 32'(2 + rdly + (we ? 0 : vdly + 1)));
        bus.req_valid = 1'b0;
        step;
        chk("back_idle_stall", 32'(bus.cpu_stall), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.req_base = 32'h0; bus.req_offset = 32'h0; bus.req_wdata = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        step; step;
        rst = 1'b0;
        chk("rst_valid", 32'(bus.mem_valid), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_be", 32'(bus.mem_be), 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_err", 32'(bus.cpu_err), 0);
        chk("rst_stall", 32'(bus.cpu_stall), 0);

        access(1'b1, 2'd2, 1'b0, 32'h100, 32'd4, 32'hDEADBEEF, 32'h0, 0, 0);
        access(1'b0, 2'd0, 1'b0, 32'h200, 32'd3, 32'h0, 32'h80FF_0000, 0, 1);
        access(1'b0, 2'd0, 1'b1, 32'h200, 32'd3, 32'h0, 32'h80FF_0000, 0, 1);
        access(1'b1, 2'd1, 1'b0, 32'h10, 32'd2, 32'h0000ABCD, 32'h0, 0, 0);
        access(1'b1, 2'd2, 1'b0, 32'h400, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 5, 0);
        access(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'd4, 32'h0, 32'h9ABC_8001, 1, 0);
        access(1'b0, 2'd2, 1'b0, 32'h100, 32'd2, 32'h0, 32'hA5A5_0F0F, 0, 0);
        access(1'b1, 2'd3, 1'b0, 32'h20, 32'd1, 32'hCAFE_BABE, 32'h0, 1, 0);

        for (int t = 0; t < 40; t++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, 32'($urandom_range(0, 63)) - 32'd32, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Load that never gets a response: 10 cycles across REQ and WAIT, then abort.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_base = 32'h300; bus.req_offset = 32'h0;
        #1;
        n = 0;
        for (int k = 0; k < 40 && bus.cpu_stall; k++) begin
            n++;
            bus.mem_ready = (k == 1);
            step;
        end
        bus.mem_ready = 1'b0;
        chk("tmo_stall_cycles", 32'(n), 11);
        chk("tmo_err", 32'(bus.cpu_err), 1);
        chk("tmo_rdata", bus.cpu_rdata, 0);
        chk("tmo_valid", 32'(bus.mem_valid), 0);
        bus.req_valid = 1'b0;
        step;
        chk("tmo_err_clear", 32'(bus.cpu_err), 0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        step;
        bus.mem_rvalid = 1'b0;
        chk("late_rvalid_rdata", bus.cpu_rdata, 0);
        chk("late_rvalid_stall", 32'(bus.cpu_stall), 0);
        access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0BAD_F00D, 0, 0);

        // Reset while waiting for read data; the straggling response must be ignored.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_base = 32'h500; bus.req_offset = 32'h0;
        step;
        bus.mem_ready = 1'b1;
        step;
        bus.mem_ready = 1'b0; bus.req_valid = 1'b0; rst = 1'b1;
        step;
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        step;
        bus.mem_rvalid = 1'b0;
        chk("rstw_stall", 32'(bus.cpu_stall), 0);
        chk("rstw_rdata", bus.cpu_rdata, 0);
        chk("rstw_err", 32'(bus.cpu_err), 0);
        chk("rstw_valid", 32'(bus.mem_valid), 0);
        access(1'b0, 2'd2, 1'b0, 32'h100, 32'h2, 32'h0, 32'h7777_1111, 0, 0);
        access(1'b0, 2'd1, 1'b1, 32'h600, 32'h6, 32'h0, 32'hFEDC_BA98, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
